// File: rtl/fetch_unit.sv
// IF stage plus IF/ID pipeline register: owns the PC, fetches from instruction memory,
// and redirects on branch/jump/illegal decisions made for the instruction held in ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] ILLEGAL_VEC = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  id_op,
  output logic [5:0]  id_func,
  output logic        illegal
);

  typedef enum logic [1:0] {
    PCS_SEQ     = 2'b00,
    PCS_BRANCH  = 2'b01,
    PCS_JUMP    = 2'b10,
    PCS_ILLEGAL = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_BUBBLE,
    ACT_FETCH
  } act_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        illegal_q, illegal_d;

  logic [31:0] pc_plus4;
  logic [31:0] bpc;
  logic [31:0] jpc;
  pcsrc_e      eff_src;
  act_e        act;

  assign pc_plus4 = pc_q + 32'd4;
  assign bpc      = id_pc4_q + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
  assign jpc      = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};

  // A bubble in ID carries no decision, so its pcsource is treated as sequential.
  assign eff_src = id_valid_q ? pcsrc_e'(pcsource) : PCS_SEQ;

  always_comb begin
    act = ACT_FETCH;
    if (stall) begin
      act = ACT_HOLD;
    end else if (eff_src != PCS_SEQ) begin
      act = ACT_REDIRECT;
    end else if (!imem_ready) begin
      act = ACT_BUBBLE;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    illegal_d  = 1'b0;
    case (act)
      ACT_HOLD: begin
      end
      ACT_REDIRECT: begin
        // The word fetched this cycle is on the wrong path and is dropped.
        id_inst_d  = 32'h0;
        id_pc4_d   = 32'h0;
        id_valid_d = 1'b0;
        case (eff_src)
          PCS_BRANCH: pc_d = bpc;
          PCS_JUMP:   pc_d = jpc;
          default: begin
            pc_d      = ILLEGAL_VEC;
            illegal_d = 1'b1;
          end
        endcase
      end
      ACT_BUBBLE: begin
        id_inst_d  = 32'h0;
        id_pc4_d   = 32'h0;
        id_valid_d = 1'b0;
      end
      default: begin
        id_inst_d  = imem_rdata;
        id_pc4_d   = pc_plus4;
        id_valid_d = 1'b1;
        pc_d       = pc_plus4;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_inst_q  <= 32'h0;
      id_pc4_q   <= 32'h0;
      id_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;
  assign id_op     = id_inst_q[31:26];
  assign id_func   = id_inst_q[5:0];
  assign illegal   = illegal_q;

endmodule
